// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  serial_add_pkg
//  Shared types and helpers for the bit-serial adder controller.
//  Revision: 1.0
// ============================================================================
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bit-counter width: enough to reach WIDTH-1, never narrower than one bit.
  function automatic int sa_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
`default_nettype none
// ============================================================================
//  fa_cell
//  Single combinational full-adder cell, shared across all bit positions.
//  Revision: 1.0
// ============================================================================
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  serial_add_ctrl
//  Bit-serial adder: one full-adder cell walks WIDTH bits LSB first, with the
//  ripple carry held in a flop. Valid/ready on both operand and result sides.
//  Revision: 1.0
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = sa_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  sa_state_t        r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;

  logic             w_s;
  logic             w_cout;
  logic             w_run;
  logic [WIDTH-1:0] w_sum_next;

  assign w_run = (r_state == RUN);

  fa_cell u_fa (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Partial sum bits collect here so that sum only ever shows complete results.
  if (WIDTH == 1) begin : g_sum_w1
    assign w_sum_next = w_s;
  end else begin : g_sum_wn
    logic [WIDTH-2:0] r_part;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_part <= '0;
      end else if (w_run) begin
        r_part <= w_sum_next[WIDTH-1:1];
      end
    end

    assign w_sum_next = {w_s, r_part};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_cout;
          if (r_cnt == c_cnt_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_serial_add_ctrl
//  Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
//  Revision: 1.0
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [W-1:0] a, b, sum;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [0:0]   a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic add8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input bit chk_lat, input int hold);
    logic [8:0] e;
    logic [8:0] held;
    int k;
    e = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    check("in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    if (chk_lat) check("latency", 32'(k), 32'(W));
    check("sum", 32'(sum), 32'(e[7:0]));
    check("cout", 32'(cout), 32'(e[8]));
    held = {cout, sum};
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      a = 8'h01; b = 8'h01; cin = 1'b0;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({cout, sum}), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drop", 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  logic [8:0] expq[$];
  int         acc[$];
  logic [7:0] sa_tbl [4] = '{8'h01, 8'h80, 8'h7F, 8'hC3};
  logic [7:0] sb_tbl [4] = '{8'h02, 8'h80, 8'h01, 8'h3C};
  logic       sc_tbl [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_state", 32'({out_valid, busy, cout, sum}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic adds and carry boundaries
    add8(8'h5A, 8'h33, 1'b0, 1'b1, 0);
    add8(8'hFF, 8'h01, 1'b0, 1'b1, 0);
    add8(8'hFF, 8'hFF, 1'b1, 1'b1, 0);
    add8(8'h00, 8'h00, 1'b0, 1'b1, 0);

    // Consumer back-pressure in DONE with a stray in_valid pulse
    add8(8'hA5, 8'h5A, 1'b1, 1'b0, 5);

    // Reset mid-run at bit 3
    out_ready = 1'b1;
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_mid_state", 32'({out_valid, busy, cout, sum}), 32'd0);
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    add8(8'h10, 8'h0F, 1'b0, 1'b1, 0);

    // Streaming with both handshakes tied high
    begin
      int  n;
      bit  accepted;
      int  nres;
      n = 0; nres = 0;
      a = sa_tbl[0]; b = sb_tbl[0]; cin = sc_tbl[0];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
        @(negedge clk);
        if (out_valid) begin
          nres++;
          if (expq.size() > 0) check("stream_data", 32'({cout, sum}), 32'(expq.pop_front()));
          else check("stream_extra", 32'd1, 32'd0);
        end
        accepted = in_ready && in_valid;
        if (accepted) begin
          expq.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
          acc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (accepted) begin
          n++;
          if (n == 4) in_valid = 1'b0;
          else begin a = sa_tbl[n]; b = sb_tbl[n]; cin = sc_tbl[n]; end
        end
      end
      out_ready = 1'b0;
      check("stream_accepts", 32'(acc.size()), 32'd4);
      check("stream_results", 32'(nres), 32'd4);
      for (int i = 1; i < acc.size(); i++)
        check("stream_period", 32'(acc[i] - acc[i-1]), 32'(W + 2));
    end

    // Random scoreboard
    for (int i = 0; i < 1000; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);

    // WIDTH=1 build, all input combinations
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cv;
      logic [1:0] e1;
      int k;
      cv = 3'(c);
      e1 = {1'b0, cv[2]} + {1'b0, cv[1]} + {1'b0, cv[0]};
      a1 = cv[2]; b1 = cv[1]; cin1 = cv[0]; in_valid1 = 1'b1;
      check("w1_in_ready", 32'(in_ready1), 32'd1);
      tick();
      in_valid1 = 1'b0;
      k = 0;
      while (!out_valid1 && k < 20) begin tick(); k++; end
      check("w1_latency", 32'(k), 32'd1);
      check("w1_result", 32'({cout1, sum1}), 32'(e1));
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("w1_drop", 32'({out_valid1, in_ready1}), 32'b01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
